// File: rtl/aes_decrypt_controller.sv
// aes_decrypt_controller
//
// Control sequencer for the AES-128 decryption datapath. Converts the
// software START/DONE register handshake into a per-cycle schedule:
// key-expansion wait, state load, initial AddRoundKey, nine full inverse
// rounds and a final inverse round. Holds no datapath state.
//
// Parameters:
//   KEYEXP_CYCLES  cycles the key-expansion unit needs (1..255)
//   SUB_CYCLES     cycles per InvSubBytes, S-box ROM latency (1..4)
//
// Ports:
//   CLK            clock
//   RESET          synchronous, active-high reset
//   AES_START      start request level from the start register
//   AES_DONE       decryption complete, held until AES_START is low
//   BUSY           high in every state except IDLE and DONE
//   KEY_EXP_START  one-cycle pulse launching key expansion
//   STATE_LD       datapath loads its state register at end of this cycle
//   OP_SEL         state-register source: 0 MSG_ENC, 1 AddRoundKey,
//                  2 InvShiftRows, 3 InvSubBytes, 4 InvMixColumns
//   ROUND_IDX      round-key index for AddRoundKey (0 outside ARK states)
//   MIX_WORD       column processed by InvMixColumns (0 outside MIX)
//
// Build option:
//   AES_CTRL_ABORT_EN  when defined, AES_START sampled low in any busy
//                      state returns the sequencer to IDLE.
//
// State table:
//   state    | meaning
//   IDLE     | waiting for AES_START
//   KEYEXP   | waiting KEYEXP_CYCLES for key expansion, pulse on first cycle
//   LOAD     | load ciphertext into the state register
//   ARK_INIT | AddRoundKey with round key 10, round counter set to 9
//   SHIFT    | InvShiftRows
//   SUB      | InvSubBytes, load on last of SUB_CYCLES cycles
//   ARK      | AddRoundKey with round key r, r=0 finishes
//   MIX      | InvMixColumns, one column per cycle, then r decrements
//   DONE     | AES_DONE high until AES_START is seen low

module aes_decrypt_controller #(
  parameter int KEYEXP_CYCLES = 12,
  parameter int SUB_CYCLES    = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEY_EXP_START,
  output logic       STATE_LD,
  output logic [2:0] OP_SEL,
  output logic [3:0] ROUND_IDX,
  output logic [1:0] MIX_WORD
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEYEXP,
    S_LOAD,
    S_ARK_INIT,
    S_SHIFT,
    S_SUB,
    S_ARK,
    S_MIX,
    S_DONE
  } state_t;

  localparam logic [7:0] KEYEXP_LAST = 8'(KEYEXP_CYCLES - 1);
  localparam logic [1:0] SUB_LAST    = 2'(SUB_CYCLES - 1);

  localparam logic [2:0] OP_MSG   = 3'd0;
  localparam logic [2:0] OP_ARK   = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MIX   = 3'd4;

  state_t     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [1:0] sub_q, sub_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] mix_q, mix_d;

  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       kes_q, kes_d;
  logic       ld_q, ld_d;
  logic [2:0] op_q, op_d;
  logic [3:0] ridx_q, ridx_d;
  logic [1:0] mixw_q, mixw_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sub_d   = sub_q;
    rnd_d   = rnd_q;
    mix_d   = mix_q;

    case (state_q)
      S_IDLE: begin
        if (AES_START) begin
          state_d = S_KEYEXP;
          cyc_d   = KEYEXP_LAST;
        end
      end
      S_KEYEXP: begin
        if (cyc_q == 8'd0) state_d = S_LOAD;
        else               cyc_d   = cyc_q - 8'd1;
      end
      S_LOAD: state_d = S_ARK_INIT;
      S_ARK_INIT: begin
        rnd_d   = 4'd9;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sub_d   = SUB_LAST;
        state_d = S_SUB;
      end
      S_SUB: begin
        if (sub_q == 2'd0) state_d = S_ARK;
        else               sub_d   = sub_q - 2'd1;
      end
      S_ARK: begin
        if (rnd_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MIX;
          mix_d   = 2'd0;
        end
      end
      S_MIX: begin
        if (mix_q == 2'd3) begin
          // rnd_q is at least 1 here, since ARK with r=0 never enters MIX
          state_d = S_SHIFT;
          rnd_d   = rnd_q - 4'd1;
          mix_d   = 2'd0;
        end else begin
          mix_d = mix_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!AES_START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AES_CTRL_ABORT_EN
    if (state_q != S_IDLE && state_q != S_DONE && !AES_START) begin
      state_d = S_IDLE;
      cyc_d   = 8'd0;
      sub_d   = 2'd0;
      rnd_d   = 4'd0;
      mix_d   = 2'd0;
    end
`endif

    // Outputs are decoded from the next state so the registered copies
    // line up with the state they describe.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    kes_d  = (state_q == S_IDLE) && (state_d == S_KEYEXP);
    ld_d   = 1'b0;
    op_d   = OP_MSG;
    ridx_d = 4'd0;
    mixw_d = 2'd0;

    case (state_d)
      S_LOAD: begin
        ld_d = 1'b1;
        op_d = OP_MSG;
      end
      S_ARK_INIT: begin
        ld_d   = 1'b1;
        op_d   = OP_ARK;
        ridx_d = 4'd10;
      end
      S_SHIFT: begin
        ld_d = 1'b1;
        op_d = OP_SHIFT;
      end
      S_SUB: begin
        // The S-box ROM result is only valid on the last SUB cycle.
        ld_d = (sub_d == 2'd0);
        op_d = OP_SUB;
      end
      S_ARK: begin
        ld_d   = 1'b1;
        op_d   = OP_ARK;
        ridx_d = rnd_d;
      end
      S_MIX: begin
        ld_d   = 1'b1;
        op_d   = OP_MIX;
        mixw_d = mix_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cyc_q   <= 8'd0;
      sub_q   <= 2'd0;
      rnd_q   <= 4'd0;
      mix_q   <= 2'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      kes_q   <= 1'b0;
      ld_q    <= 1'b0;
      op_q    <= OP_MSG;
      ridx_q  <= 4'd0;
      mixw_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sub_q   <= sub_d;
      rnd_q   <= rnd_d;
      mix_q   <= mix_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      kes_q   <= kes_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      ridx_q  <= ridx_d;
      mixw_q  <= mixw_d;
    end
  end

  assign AES_DONE      = done_q;
  assign BUSY          = busy_q;
  assign KEY_EXP_START = kes_q;
  assign STATE_LD      = ld_q;
  assign OP_SEL        = op_q;
  assign ROUND_IDX     = ridx_q;
  assign MIX_WORD      = mixw_q;

endmodule
